irq_controller: RTL and testbench
=================================

# irq_controller

Vectored Z80 mode-2 interrupt controller between the peripherals (UART, USB, SD, video, GPIO) and the tv80s `int_n` input, which is currently tied high. Collects up to eight interrupt sources, applies masking, edge/level mode and fixed priority with nesting, and drives `int_n`. It answers the CPU's interrupt-acknowledge cycle (M1+IORQ) with an 8-bit vector, and exposes an I/O register window selected by the address decoder.

## Interface
Parameters:
- NSRC, 8, number of sources (fixed 8; index 0 = highest priority)

Ports:
- clk_i  in  1  system clock, same as CPU
- rst_n_i  in  1  asynchronous, active-low reset
- irq_cs  in  1  register window select from addr_decoder (I/O space)
- wr_n  in  1  CPU write strobe, active low
- m1_n  in  1  CPU M1
- iorq_n  in  1  CPU IORQ
- reg_addr_i  in  3  register index (cpu_addr[2:0])
- data_i  in  8  CPU write data
- irq_i  in  8  source requests, active high, synchronous to clk_i
- data_o  out  8  register read data, or vector while ack_o=1
- ack_o  out  1  vector on bus; top-level mux gives it priority over all chip selects
- int_n_o  out  1  to tv80s int_n

## Operation
- Registers (index: name):
  - 0 MASK: RW, 1 = source enabled.
  - 1 PEND: R; W1C for edge latches.
  - 2 EDGE: RW, 1 = rising-edge latched, 0 = level.
  - 3 VBASE: RW bits 7:4; bits 3:0 read 0.
  - 4 CTRL: bit0 GIE; bit7 read-only = ~int_n_o.
  - 5 ISR: R in-service bits; write = EOI, clears ISR bit data_i[2:0].
  - 6 CUR: R {valid, 4'b0, id} of last acknowledged source.
  - 7 RAW: R irq_i.
- Writes take effect every cycle with irq_cs=1 and wr_n=0; all writes are idempotent, so multi-cycle strobes are safe.
- Reads: data_o = selected register when irq_cs=1 and ack_o=0; otherwise 0x00.
- Edge latch: set when EDGE[i]=1 and irq_i[i] rises (prev=0, now=1, prev register reset 0). Set wins over a simultaneous W1C. Cleared when its source is acknowledged.
- PEND[i] = EDGE[i] ? latch[i] : irq_i[i].
- Blocking: if ISR nonzero, let k = lowest set ISR index; sources with index >= k are blocked. Strictly higher-priority sources nest.
- eligible = PEND & MASK & ~blocked, gated by GIE. Winner = lowest set index of eligible.
- Vector = {VBASE[7:4], id[2:0], 1'b0}.
- FSM:
  - IDLE: int_n_o=1. Go to REQ when eligible != 0.
  - REQ: int_n_o=0; winner re-evaluated every cycle. If m1_n=0 and iorq_n=0, latch winner id, set ISR[id], clear edge latch[id], CUR={1,id}, go to ACK. Otherwise, if eligible==0 (masked, cleared, GIE off), go to IDLE. Ack takes precedence over a same-cycle drop. If an ack arrives while eligible==0, use id 7 and flag nothing in ISR/CUR (spurious).
  - ACK: int_n_o=1, ack_o=1, data_o=latched vector. Go to IDLE when iorq_n=1.
- Acknowledge seen in IDLE or ACK: ignored.
- EOI for an id not in service: no effect.

## Timing
- Reset values: int_n_o=1, ack_o=0, data_o=0x00, MASK=EDGE=VBASE=CTRL=0, latches=0, ISR=0, CUR=0, FSM=IDLE.
- Reset is asynchronous, including mid-ACK: ack_o and int_n_o release immediately.
- All state, int_n_o and ack_o are registered.
- irq_i rising edge to int_n_o low: 2 cycles (edge detect/latch, then FSM).
- Level source to int_n_o low: 1 cycle after the rising edge at which irq_i is sampled high.
- M1+IORQ sampled low at edge N: ack_o=1 and vector valid from edge N+1. This falls within tv80s's automatic acknowledge wait states.
- ack_o falls 1 cycle after iorq_n is sampled high.
- Register write to effect on eligibility: next cycle. MASK clear while in REQ deasserts int_n_o 1 cycle later.

## Test plan
- Level source 3: MASK=0x08, VBASE=0x40, GIE=1, hold irq_i[3]; drive M1+IORQ low -> int_n_o low, vector 0x46 with ack_o=1, ISR=0x08, CUR=0x83.
- Priority and nesting: sources 5 and 2 pending, both enabled -> vector id 2. Raise source 0 during service -> second request and vector id 0. Source 5 stays blocked until EOI(0) and EOI(2).
- Edge mode: EDGE=0x01, pulse irq_i[0] one cycle -> PEND=0x01 persists. W1C in the same cycle as a new rising edge leaves PEND=0x01. Ack clears the latch.
- Drop before ack: request, then MASK=0 in REQ -> int_n_o high 1 cycle later, FSM IDLE. Ack in the same cycle as the drop -> valid vector, ISR set.
- Spurious ack: GIE=0, drive M1+IORQ low in IDLE -> ack_o stays 0, ISR unchanged.
- Async reset asserted mid-ACK -> ack_o=0 and int_n_o=1 immediately; all registers read 0 after reset.

Source files
------------

// File: rtl/irq_controller.sv
// irq_controller: Z80 mode-2 vectored interrupt controller with masking, edge/level sources and nested fixed priority.
module irq_controller #(
  parameter int NSRC = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            irq_cs,
  input  logic            wr_n,
  input  logic            m1_n,
  input  logic            iorq_n,
  input  logic [2:0]      reg_addr_i,
  input  logic [7:0]      data_i,
  input  logic [NSRC-1:0] irq_i,
  output logic [7:0]      data_o,
  output logic            ack_o,
  output logic            int_n_o
);
  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;
  state_t          state;
  logic [NSRC-1:0] mask, edge_en, latch, prev, isr, pend, isr_lo, blocked, elig;
  logic [NSRC-1:0] take_mask, eoi_mask, w1c_mask, latch_nx, isr_nx;
  logic [3:0]      vbase;
  logic            gie, cur_valid, ack_req, take;
  logic [2:0]      cur_id, vec_id, win;
  logic [7:0]      we, rd_val;
  assign we        = (irq_cs && !wr_n) ? 8'd1 << reg_addr_i : 8'd0;
  assign pend      = (edge_en & latch) | (~edge_en & irq_i);
  // Isolate lowest in-service bit; everything at or below its priority is blocked.
  assign isr_lo    = isr & (~isr + NSRC'(1));
  assign blocked   = ~(isr_lo - NSRC'(1));
  assign elig      = gie ? pend & mask & ~blocked : '0;
  assign ack_req   = state == REQ && !m1_n && !iorq_n;
  assign take      = ack_req && |elig;
  assign take_mask = take ? NSRC'(1) << win : '0;
  assign eoi_mask  = we[5] ? NSRC'(1) << data_i[2:0] : '0;
  assign w1c_mask  = we[1] ? data_i : '0;
  // A new rising edge wins over a same-cycle W1C or acknowledge clear.
  assign latch_nx  = (latch & ~w1c_mask & ~take_mask) | (edge_en & irq_i & ~prev);
  assign isr_nx    = (isr & ~eoi_mask) | take_mask;
  always_comb begin
    win = 3'd7;
    for (int i = NSRC - 1; i >= 0; i--)
      if (elig[i]) win = i[2:0];
  end
  always_comb begin
    case (reg_addr_i)
      3'd0:    rd_val = mask;
      3'd1:    rd_val = pend;
      3'd2:    rd_val = edge_en;
      3'd3:    rd_val = {vbase, 4'h0};
      3'd4:    rd_val = {~int_n_o, 6'b0, gie};
      3'd5:    rd_val = isr;
      3'd6:    rd_val = {cur_valid, 4'b0, cur_id};
      default: rd_val = irq_i;
    endcase
  end
  assign data_o = ack_o ? {vbase, vec_id, 1'b0} : irq_cs ? rd_val : 8'h00;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      mask      <= '0;
      edge_en   <= '0;
      vbase     <= '0;
      gie       <= 1'b0;
      latch     <= '0;
      prev      <= '0;
      isr       <= '0;
      cur_valid <= 1'b0;
      cur_id    <= '0;
      vec_id    <= '0;
      int_n_o   <= 1'b1;
      ack_o     <= 1'b0;
    end else begin
      prev  <= irq_i;
      latch <= latch_nx;
      isr   <= isr_nx;
      if (we[0]) mask <= data_i;
      if (we[2]) edge_en <= data_i;
      if (we[3]) vbase <= data_i[7:4];
      if (we[4]) gie <= data_i[0];
      if (take) begin
        cur_valid <= 1'b1;
        cur_id    <= win;
      end
      case (state)
        IDLE: if (|elig) begin
          state   <= REQ;
          int_n_o <= 1'b0;
        end
        REQ: if (ack_req) begin
          state   <= ACK;
          int_n_o <= 1'b1;
          ack_o   <= 1'b1;
          vec_id  <= win;
        end else if (!(|elig)) begin
          state   <= IDLE;
          int_n_o <= 1'b1;
        end
        ACK: if (iorq_n) begin
          state <= IDLE;
          ack_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: self-checking bench; expected vectors queued at each acknowledge, compared on ack_o rise.
module tb_irq_controller;
  logic       clk_i = 0, rst_n_i = 0, irq_cs = 0, wr_n = 1, m1_n = 1, iorq_n = 1;
  logic [2:0] reg_addr_i = 0;
  logic [7:0] data_i = 0, irq_i = 0, data_o;
  logic       ack_o, int_n_o, ack_d = 0;
  logic [7:0] exp_q[$];
  int         n_tests = 0, n_fail = 0;

  irq_controller #(.NSRC(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .irq_cs(irq_cs), .wr_n(wr_n), .m1_n(m1_n),
    .iorq_n(iorq_n), .reg_addr_i(reg_addr_i), .data_i(data_i), .irq_i(irq_i),
    .data_o(data_o), .ack_o(ack_o), .int_n_o(int_n_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (ack_o && !ack_d) begin
      if (exp_q.size() == 0) check("unexpected_ack", ack_o, 8'h00);
      else check("vector", data_o, exp_q.pop_front());
      check("int_n_in_ack", int_n_o, 8'h01);
    end
    ack_d = ack_o;
  end

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk_i);
    irq_cs = 1; wr_n = 0; reg_addr_i = a; data_i = d;
    @(negedge clk_i);
    irq_cs = 0; wr_n = 1;
  endtask

  task automatic rdchk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] v;
    @(negedge clk_i);
    irq_cs = 1; wr_n = 1; reg_addr_i = a;
    #1 v = data_o;
    irq_cs = 0;
    check(tag, v, exp);
  endtask

  task automatic do_ack(input logic [7:0] v);
    @(negedge clk_i);
    exp_q.push_back(v); m1_n = 0; iorq_n = 0;
    @(negedge clk_i);
    check("ack_rise", ack_o, 8'h01);
    @(negedge clk_i);
    m1_n = 1; iorq_n = 1;
    @(negedge clk_i);
    check("ack_fall", ack_o, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_int_n", int_n_o, 8'h01);
    check("rst_ack", ack_o, 8'h00);
    check("rst_data", data_o, 8'h00);
    @(negedge clk_i) rst_n_i = 1;
    // Level source 3
    wr(0, 8'h08); wr(3, 8'h4F); wr(4, 8'h01);
    rdchk("vbase", 3, 8'h40);
    @(negedge clk_i) irq_i = 8'h08;
    check("lvl_int_pre", int_n_o, 8'h01);
    @(negedge clk_i) check("lvl_int_n", int_n_o, 8'h00);
    rdchk("ctrl_req", 4, 8'h81);
    rdchk("pend_lvl", 1, 8'h08);
    do_ack(8'h46);
    rdchk("isr_3", 5, 8'h08);
    rdchk("cur_3", 6, 8'h83);
    rdchk("raw", 7, 8'h08);
    rdchk("ctrl_ack", 4, 8'h01);
    @(negedge clk_i) irq_i = 8'h00;
    wr(5, 8'h03);
    rdchk("isr_eoi3", 5, 8'h00);
    // Priority and nesting
    wr(0, 8'h25);
    @(negedge clk_i) irq_i = 8'h24;
    @(negedge clk_i) check("prio_int_n", int_n_o, 8'h00);
    do_ack(8'h44);
    rdchk("isr_2", 5, 8'h04);
    @(negedge clk_i) irq_i = 8'h25;
    @(negedge clk_i) check("nest_int_n", int_n_o, 8'h00);
    do_ack(8'h40);
    rdchk("isr_20", 5, 8'h05);
    @(negedge clk_i) irq_i = 8'h20;
    wr(5, 8'h00);
    @(negedge clk_i);
    @(negedge clk_i) check("blk5_int_n", int_n_o, 8'h01);
    rdchk("isr_after_eoi0", 5, 8'h04);
    wr(5, 8'h02);
    @(negedge clk_i) check("src5_int_n", int_n_o, 8'h00);
    do_ack(8'h4A);
    rdchk("cur_5", 6, 8'h85);
    @(negedge clk_i) irq_i = 8'h00;
    wr(5, 8'h05);
    rdchk("isr_clear", 5, 8'h00);
    // Edge mode on source 0
    wr(0, 8'h01); wr(2, 8'h01);
    rdchk("edge_rd", 2, 8'h01);
    @(negedge clk_i) irq_i = 8'h01;
    @(negedge clk_i) irq_i = 8'h00;
    check("edge_int_pre", int_n_o, 8'h01);
    @(negedge clk_i) check("edge_int_n", int_n_o, 8'h00);
    rdchk("pend_latch", 1, 8'h01);
    @(negedge clk_i);
    irq_i = 8'h01; irq_cs = 1; wr_n = 0; reg_addr_i = 3'd1; data_i = 8'h01;
    @(negedge clk_i);
    irq_i = 8'h00; irq_cs = 0; wr_n = 1;
    rdchk("pend_set_wins", 1, 8'h01);
    wr(1, 8'h01);
    rdchk("pend_w1c", 1, 8'h00);
    @(negedge clk_i) check("w1c_drop_int_n", int_n_o, 8'h01);
    @(negedge clk_i) irq_i = 8'h01;
    @(negedge clk_i) irq_i = 8'h00;
    @(negedge clk_i) check("edge2_int_n", int_n_o, 8'h00);
    do_ack(8'h40);
    rdchk("pend_ack_clr", 1, 8'h00);
    wr(5, 8'h00); wr(2, 8'h00);
    // Drop before ack, then ack in the drop cycle
    wr(0, 8'h08);
    @(negedge clk_i) irq_i = 8'h08;
    @(negedge clk_i) check("drop_req", int_n_o, 8'h00);
    wr(0, 8'h00);
    check("drop_int_hold", int_n_o, 8'h00);
    @(negedge clk_i) check("drop_int_n", int_n_o, 8'h01);
    wr(0, 8'h08);
    @(negedge clk_i) check("req_again", int_n_o, 8'h00);
    exp_q.push_back(8'h46);
    irq_cs = 1; wr_n = 0; reg_addr_i = 3'd0; data_i = 8'h00; m1_n = 0; iorq_n = 0;
    @(negedge clk_i);
    irq_cs = 0; wr_n = 1;
    check("drop_ack_rise", ack_o, 8'h01);
    @(negedge clk_i) begin m1_n = 1; iorq_n = 1; end
    @(negedge clk_i) check("drop_ack_fall", ack_o, 8'h00);
    rdchk("drop_isr", 5, 8'h08);
    @(negedge clk_i) irq_i = 8'h00;
    wr(5, 8'h03);
    // Spurious acknowledge while idle
    wr(4, 8'h00);
    @(negedge clk_i) begin m1_n = 0; iorq_n = 0; end
    @(negedge clk_i) check("spur_ack", ack_o, 8'h00);
    @(negedge clk_i) begin m1_n = 1; iorq_n = 1; end
    rdchk("spur_isr", 5, 8'h00);
    // Asynchronous reset in the middle of an acknowledge
    wr(4, 8'h01); wr(0, 8'h08);
    @(negedge clk_i) irq_i = 8'h08;
    @(negedge clk_i) begin exp_q.push_back(8'h46); m1_n = 0; iorq_n = 0; end
    @(negedge clk_i) check("mid_ack", ack_o, 8'h01);
    #2 rst_n_i = 0;
    #1;
    check("rst_ack_rel", ack_o, 8'h00);
    check("rst_int_rel", int_n_o, 8'h01);
    irq_i = 8'h00; m1_n = 1; iorq_n = 1;
    for (int a = 0; a < 8; a++) rdchk($sformatf("rst_reg%0d", a), 3'(a), 8'h00);
    @(negedge clk_i) rst_n_i = 1;
    rdchk("post_rst_isr", 5, 8'h00);
    check("sb_empty", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
